// File: rtl/random_roller_multi.sv
`timescale 1ns/1ps
// LFSR dice roller: a start key launches a roll that slows down level by level, a stop key
// freezes it early, and committed results are kept in a short history the show key browses.
module random_roller_multi #(
    parameter int          WIDTH           = 4,
    parameter int          MAX_VAL         = 15,
    parameter logic [15:0] SEED            = 16'hACE1,
    parameter int          BASE_INTERVAL   = 2_500_000,
    parameter int          STEPS_PER_LEVEL = 8,
    parameter int          NUM_LEVELS      = 4,
    parameter int          HIST_DEPTH      = 4,
    parameter int          SHOW_CYCLES     = 50_000_000
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic                          i_stop,
    input  logic                          i_show,
    output logic [WIDTH-1:0]              o_random_out,
    output logic                          o_busy,
    output logic                          o_showing,
    output logic [$clog2(HIST_DEPTH)-1:0] o_show_idx
);
    localparam int IDX_W   = $clog2(HIST_DEPTH);
    localparam int HCNT_W  = $clog2(HIST_DEPTH + 1);
    localparam int MAX_INT = BASE_INTERVAL << (NUM_LEVELS - 1);
    localparam int CNT_W   = $clog2(MAX_INT + 1);
    localparam int STEP_W  = (STEPS_PER_LEVEL > 1) ? $clog2(STEPS_PER_LEVEL) : 1;
    localparam int LVL_W   = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
    localparam int TMR_W   = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    localparam logic [WIDTH-1:0]  MAX_L     = WIDTH'(MAX_VAL);
    localparam logic [CNT_W-1:0]  BASE_L    = CNT_W'(BASE_INTERVAL);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS_PER_LEVEL - 1);
    localparam logic [LVL_W-1:0]  LVL_LAST  = LVL_W'(NUM_LEVELS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SHOW_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_FULL = HCNT_W'(HIST_DEPTH);
    localparam logic [HCNT_W-1:0] HCNT_TWO  = HCNT_W'(2);

    typedef enum logic [1:0] {IDLE, ROLL, HOLD, SHOW} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         key_reg, key_prev_reg;
    logic               start_edge, stop_edge, show_edge;
    logic [15:0]        lfsr_reg, lfsr_next;
    logic [WIDTH-1:0]   raw_val, cand_val;
    logic [WIDTH-1:0]   out_reg, out_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next, interval_reg, interval_next;
    logic [STEP_W-1:0]  step_reg, step_next;
    logic [LVL_W-1:0]   level_reg, level_next;
    logic [IDX_W-1:0]   idx_reg, idx_next, idx_inc;
    logic [TMR_W-1:0]   timer_reg, timer_next;
    logic [HCNT_W-1:0]  count_reg, count_next;
    logic               push;
    logic [WIDTH-1:0]   push_val;
    logic [WIDTH-1:0]   hist_reg  [HIST_DEPTH];
    logic [WIDTH-1:0]   hist_next [HIST_DEPTH];

    // Keys are registered once more so each press yields a single-cycle edge.
    assign start_edge = key_reg[0] & ~key_prev_reg[0];
    assign stop_edge  = key_reg[1] & ~key_prev_reg[1];
    assign show_edge  = key_reg[2] & ~key_prev_reg[2];

    assign lfsr_next = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ 16'hB400) : (lfsr_reg >> 1);
    assign raw_val   = lfsr_reg[WIDTH-1:0];
    assign cand_val  = (raw_val > MAX_L) ? raw_val - (MAX_L + 1'b1) : raw_val;

    assign idx_inc    = (HCNT_W'(idx_reg) == count_reg - 1'b1) ? IDX_W'(1) : idx_reg + 1'b1;
    assign count_next = (push && count_reg != HCNT_FULL) ? count_reg + 1'b1 : count_reg;

    generate
        for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                assign hist_next[gi] = push ? push_val : hist_reg[gi];
            end else begin : g_tail
                assign hist_next[gi] = push ? hist_reg[gi-1] : hist_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            key_reg      <= '0;
            key_prev_reg <= '0;
            lfsr_reg     <= SEED;
            out_reg      <= '0;
            cnt_reg      <= '0;
            interval_reg <= '0;
            step_reg     <= '0;
            level_reg    <= '0;
            idx_reg      <= '0;
            timer_reg    <= '0;
            count_reg    <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) hist_reg[i] <= '0;
        end else begin
            key_reg      <= {i_show, i_stop, i_start};
            key_prev_reg <= key_reg;
            lfsr_reg     <= lfsr_next;
            out_reg      <= out_next;
            cnt_reg      <= cnt_next;
            interval_reg <= interval_next;
            step_reg     <= step_next;
            level_reg    <= level_next;
            idx_reg      <= idx_next;
            timer_reg    <= timer_next;
            count_reg    <= count_next;
            for (int i = 0; i < HIST_DEPTH; i++) hist_reg[i] <= hist_next[i];
        end
    end

    always_comb begin
        state_next    = state_reg;
        out_next      = out_reg;
        cnt_next      = cnt_reg;
        interval_next = interval_reg;
        step_next     = step_reg;
        level_next    = level_reg;
        idx_next      = idx_reg;
        timer_next    = timer_reg;
        push          = 1'b0;
        push_val      = out_reg;
        if (start_edge) begin
            state_next    = ROLL;
            out_next      = cand_val;
            cnt_next      = '0;
            interval_next = BASE_L;
            step_next     = '0;
            level_next    = '0;
            idx_next      = '0;
            timer_next    = '0;
        end else begin
            case (state_reg)
                ROLL: begin
                    if (stop_edge) begin
                        push       = 1'b1;
                        state_next = HOLD;
                    end else if (cnt_reg == interval_reg - 1'b1) begin
                        cnt_next = '0;
                        out_next = cand_val;
                        if (step_reg == STEP_LAST) begin
                            step_next = '0;
                            // The update closing the last level is also the final result.
                            if (level_reg == LVL_LAST) begin
                                push       = 1'b1;
                                push_val   = cand_val;
                                state_next = HOLD;
                            end else begin
                                level_next    = level_reg + 1'b1;
                                interval_next = interval_reg << 1;
                            end
                        end else begin
                            step_next = step_reg + 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                IDLE, HOLD: begin
                    if (show_edge && count_reg >= HCNT_TWO) begin
                        state_next = SHOW;
                        idx_next   = IDX_W'(1);
                        out_next   = hist_reg[1];
                        timer_next = '0;
                    end
                end
                SHOW: begin
                    if (show_edge) begin
                        idx_next   = idx_inc;
                        out_next   = hist_reg[idx_inc];
                        timer_next = '0;
                    end else if (timer_reg == TMR_LAST) begin
                        state_next = HOLD;
                        idx_next   = '0;
                        out_next   = hist_reg[0];
                    end else begin
                        timer_next = timer_reg + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy       = (state_reg == ROLL);
        o_showing    = (state_reg == SHOW);
        o_random_out = out_reg;
        o_show_idx   = idx_reg;
    end

endmodule

// File: tb/tb_random_roller_multi.sv
`timescale 1ns/1ps
// Directed bench for random_roller_multi with a short schedule (2/4/8-cycle spacing, 56-cycle roll).
module tb_random_roller_multi;
    logic       clk = 1'b0;
    logic       rst_n, i_start, i_stop, i_show;
    logic [3:0] o_random_out;
    logic       o_busy, o_showing;
    logic [1:0] o_show_idx;

    int tests = 0;
    int fails = 0;

    logic [15:0] m_lfsr;
    int          upd_tbl  [12] = '{2, 4, 6, 8, 12, 16, 20, 24, 32, 40, 48, 56};
    int          stop_tbl [5]  = '{3, 5, 7, 13, 20};
    logic [3:0]  res1, res2, first1, first2, first6, fin6, fv;
    logic [3:0]  rv [5];

    random_roller_multi #(
        .WIDTH(4), .MAX_VAL(9), .SEED(16'hACE1), .BASE_INTERVAL(2),
        .STEPS_PER_LEVEL(4), .NUM_LEVELS(3), .HIST_DEPTH(4), .SHOW_CYCLES(20)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_stop(i_stop), .i_show(i_show),
        .o_random_out(o_random_out), .o_busy(o_busy), .o_showing(o_showing),
        .o_show_idx(o_show_idx)
    );

    always #5 clk = ~clk;

    // Reference Galois LFSR (taps 0xB400), running alongside the design.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    function automatic logic [3:0] cand(input logic [15:0] l);
        logic [3:0] c;
        c = l[3:0];
        return (c > 4'd9) ? c - 4'd10 : c;
    endfunction

    function automatic bit is_update(input int r);
        foreach (upd_tbl[i]) if (upd_tbl[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press_show();
        i_show = 1'b1;
        @(negedge clk);
        i_show = 1'b0;
        @(negedge clk);
    endtask

    // Two-cycle start pulse, then follow the roll cycle by cycle; stop_r > 0 presses stop
    // at roll cycle stop_r.
    task automatic do_roll(input int stop_r, output logic [3:0] result, output logic [3:0] first);
        logic [3:0] cp, exp;
        int r, busy_cycles;
        i_start = 1'b1;
        @(negedge clk);
        check("busy_pre", 32'(o_busy), 0);
        cp = cand(m_lfsr);
        @(negedge clk);
        i_start = 1'b0;
        exp = cp;
        first = cp;
        r = 1;
        busy_cycles = 0;
        while (o_busy === 1'b1 && r < 200) begin
            if (r == stop_r)     i_stop = 1'b1;
            if (r == stop_r + 1) i_stop = 1'b0;
            check("roll_val", 32'(o_random_out), 32'(exp));
            check("roll_range", 32'(o_random_out <= 4'd9), 1);
            busy_cycles++;
            cp = cand(m_lfsr);
            if (is_update(r) && !(stop_r > 0 && r == stop_r + 1)) exp = cp;
            @(negedge clk);
            r++;
        end
        i_stop = 1'b0;
        check("busy_len", busy_cycles, (stop_r > 0) ? stop_r + 1 : 56);
        check("roll_final", 32'(o_random_out), 32'(exp));
        check("roll_showing", 32'(o_showing), 0);
        result = exp;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_show = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out", 32'(o_random_out), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_showing", 32'(o_showing), 0);
        check("rst_idx", 32'(o_show_idx), 0);
        rst_n = 1'b1;

        // Full natural roll; LFSR advanced three times gives 0x389C -> 12 -> 2.
        press_show();
        check("show_cnt0", 32'(o_showing), 0);
        do_roll(0, res1, first1);
        check("first_val", 32'(first1), 2);
        press_show();
        check("show_cnt1", 32'(o_showing), 0);
        check("hold_val1", 32'(o_random_out), 32'(res1));

        // Early stop freezes the current value.
        do_roll(10, res2, first2);
        repeat (3) @(negedge clk);
        check("frozen_val", 32'(o_random_out), 32'(res2));
        check("frozen_busy", 32'(o_busy), 0);

        // Browse the two-entry history and let the show time out.
        press_show();
        check("show_on", 32'(o_showing), 1);
        check("show_idx1", 32'(o_show_idx), 1);
        check("show_val1", 32'(o_random_out), 32'(res1));
        repeat (19) @(negedge clk);
        check("show_last_cycle", 32'(o_showing), 1);
        @(negedge clk);
        check("show_timeout", 32'(o_showing), 0);
        check("timeout_idx", 32'(o_show_idx), 0);
        check("timeout_val", 32'(o_random_out), 32'(res2));

        // Five more committed rolls; depth 4 keeps only the last four.
        for (int i = 0; i < 5; i++) do_roll(stop_tbl[i], rv[i], fv);
        press_show();
        check("browse_idx_a", 32'(o_show_idx), 1);
        check("browse_val_a", 32'(o_random_out), 32'(rv[3]));
        repeat (3) @(negedge clk);
        press_show();
        check("browse_idx_b", 32'(o_show_idx), 2);
        check("browse_val_b", 32'(o_random_out), 32'(rv[2]));
        repeat (3) @(negedge clk);
        press_show();
        check("browse_idx_c", 32'(o_show_idx), 3);
        check("browse_val_c", 32'(o_random_out), 32'(rv[1]));
        repeat (3) @(negedge clk);
        press_show();
        check("browse_wrap_idx", 32'(o_show_idx), 1);
        check("browse_wrap_val", 32'(o_random_out), 32'(rv[3]));
        repeat (20) @(negedge clk);
        check("browse_timeout", 32'(o_showing), 0);
        check("browse_hold_val", 32'(o_random_out), 32'(rv[4]));

        // Start and stop together in HOLD: start wins, nothing is committed.
        i_start = 1'b1; i_stop = 1'b1;
        @(negedge clk);
        i_start = 1'b0; i_stop = 1'b0;
        @(negedge clk);
        check("startstop_busy", 32'(o_busy), 1);
        press_show();
        check("roll_show_ignored", 32'(o_showing), 0);
        check("roll_show_busy", 32'(o_busy), 1);
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        @(negedge clk);
        check("stop_busy", 32'(o_busy), 0);
        press_show();
        check("nocommit_val1", 32'(o_random_out), 32'(rv[4]));
        repeat (3) @(negedge clk);
        press_show();
        check("nocommit_idx2", 32'(o_show_idx), 2);
        check("nocommit_val2", 32'(o_random_out), 32'(rv[3]));

        // Start aborts the show, then reset mid-roll.
        i_start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        i_start = 1'b0;
        check("abort_busy", 32'(o_busy), 1);
        check("abort_showing", 32'(o_showing), 0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_out", 32'(o_random_out), 0);
        check("async_busy", 32'(o_busy), 0);
        check("async_showing", 32'(o_showing), 0);
        check("async_idx", 32'(o_show_idx), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        press_show();
        check("post_rst_show", 32'(o_showing), 0);
        do_roll(0, fin6, first6);
        check("post_rst_first", 32'(first6), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
